// File: rtl/cpu_ctrl_fsm_if.sv
// Control-unit bundle between the multicycle controller and the datapath/memory side.
// Carries the inputs the controller observes and every control output it drives.
//   master : the controller (observes instr/mem_ready/flags/irq, drives the controls)
//   slave  : the datapath/memory side (drives the observed signals, consumes the controls)
// Port summary:
//   instr[15:0]     instruction register contents
//   mem_ready       memory completes the current request this cycle
//   flags[4:0]      {C,L,F,Z,N} from the PSR
//   irq             level interrupt request
//   ir_load, src_en, dst_en, imm_en, reg_we, link, wb_sel[1:0], b_sel, alu_op[3:0],
//   flags_we, mem_req, mem_we, addr_sel, pc_op[1:0], pc_vec, irq_ack, halted,
//   err_code[1:0]   controller outputs
interface cpu_ctrl_fsm_if;
    logic [15:0] instr;
    logic        mem_ready;
    logic [4:0]  flags;
    logic        irq;

    logic        ir_load;
    logic        src_en;
    logic        dst_en;
    logic        imm_en;
    logic        reg_we;
    logic        link;
    logic [1:0]  wb_sel;
    logic        b_sel;
    logic [3:0]  alu_op;
    logic        flags_we;
    logic        mem_req;
    logic        mem_we;
    logic        addr_sel;
    logic [1:0]  pc_op;
    logic        pc_vec;
    logic        irq_ack;
    logic        halted;
    logic [1:0]  err_code;

    modport master (
        input  instr, mem_ready, flags, irq,
        output ir_load, src_en, dst_en, imm_en, reg_we, link, wb_sel, b_sel, alu_op,
               flags_we, mem_req, mem_we, addr_sel, pc_op, pc_vec, irq_ack, halted, err_code
    );

    modport slave (
        output instr, mem_ready, flags, irq,
        input  ir_load, src_en, dst_en, imm_en, reg_we, link, wb_sel, b_sel, alu_op,
               flags_we, mem_req, mem_we, addr_sel, pc_op, pc_vec, irq_ack, halted, err_code
    );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Multicycle control unit for the 16-bit CR16-style core.
// Sequences FETCH -> DECODE -> EXEC (or MEM for LOAD/STOR) and drives the datapath
// enables and ALU/PC/writeback selects. Adds a memory ready/wait handshake with a bus
// timeout, full condition-code evaluation, one vectored interrupt with link/return and a
// sticky HALT on illegal opcodes or bus timeouts.
// Ports:
//   clk    clock
//   reset  asynchronous, active-low; all outputs forced to 0 while asserted
//   bus    cpu_ctrl_fsm_if.master: instr, mem_ready, flags, irq in; all controls out
module cpu_ctrl_fsm #(
    parameter int unsigned MEM_TIMEOUT = 16,   // 0 disables the bus timeout
    parameter int unsigned TMR_W       = 8,    // MEM_TIMEOUT must be < 2**TMR_W
    parameter int unsigned LINK_REG    = 15,
    parameter bit          IRQ_EN      = 1'b1
) (
    input logic            clk,
    input logic            reset,
    cpu_ctrl_fsm_if.master bus
);

    typedef enum logic [2:0] {
        StFetch, StDecode, StExec, StMem, StIntr, StHalt
    } state_e;

    typedef enum logic [4:0] {
        CBad, CAdd, CSub, CCmp, CAnd, COr, CXor, CMov,
        CLoad, CStor, CJal, CJcond, CLsh, CLshi, CBcond,
        CAndi, COri, CXori, CAddi, CSubi, CCmpi, CMovi, CLui
    } cls_e;

    localparam logic [TMR_W-1:0] TimeoutVal = TMR_W'(MEM_TIMEOUT);
    localparam logic [3:0]       LinkIdx    = 4'(LINK_REG);

    state_e           state_q, state_d;
    logic [TMR_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             isr_q, isr_d;
    logic [1:0]       err_q, err_d;

    cls_e       cls;
    logic [3:0] op, ext;
    logic       cond_true;
    logic       timeout_hit;
    logic       is_return;
    logic       f_c, f_l, f_f, f_z, f_n;

    assign op  = bus.instr[15:12];
    assign ext = bus.instr[7:4];
    assign {f_c, f_l, f_f, f_z, f_n} = bus.flags;

    // Saturate so a disabled timeout never lets the counter wrap back to "first cycle".
    assign cnt_inc     = (cnt_q == {TMR_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_inc == TimeoutVal);
    assign is_return   = (bus.instr[11:8] == 4'b1110) && (bus.instr[3:0] == LinkIdx) && isr_q;

    always_comb begin
        cls = CBad;
        case (op)
            4'b0000: begin
                case (ext)
                    4'b0101: cls = CAdd;
                    4'b1001: cls = CSub;
                    4'b1011: cls = CCmp;
                    4'b0001: cls = CAnd;
                    4'b0010: cls = COr;
                    4'b0011: cls = CXor;
                    4'b1101: cls = CMov;
                    default: cls = CBad;
                endcase
            end
            4'b0100: begin
                case (ext)
                    4'b0000: cls = CLoad;
                    4'b0100: cls = CStor;
                    4'b1000: cls = CJal;
                    4'b1100: cls = CJcond;
                    default: cls = CBad;
                endcase
            end
            4'b1000: begin
                if (ext == 4'b0100)        cls = CLsh;
                else if (ext[3:1] == 3'b0) cls = CLshi;
                else                       cls = CBad;
            end
            4'b1100: cls = CBcond;
            4'b0001: cls = CAndi;
            4'b0010: cls = COri;
            4'b0011: cls = CXori;
            4'b0101: cls = CAddi;
            4'b1001: cls = CSubi;
            4'b1011: cls = CCmpi;
            4'b1101: cls = CMovi;
            4'b1111: cls = CLui;
            default: cls = CBad;
        endcase
    end

    always_comb begin
        case (bus.instr[11:8])
            4'h0: cond_true = f_z;
            4'h1: cond_true = !f_z;
            4'h2: cond_true = f_c;
            4'h3: cond_true = !f_c;
            4'h4: cond_true = f_l;
            4'h5: cond_true = !f_l;
            4'h6: cond_true = f_n;
            4'h7: cond_true = !f_n;
            4'h8: cond_true = f_f;
            4'h9: cond_true = !f_f;
            4'hA: cond_true = !f_l && !f_z;
            4'hB: cond_true = f_l || f_z;
            4'hC: cond_true = !f_n && !f_z;
            4'hD: cond_true = f_n || f_z;
            4'hE: cond_true = 1'b1;
            4'hF: cond_true = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StFetch;
            cnt_q   <= '0;
            isr_q   <= 1'b0;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            isr_q   <= isr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        isr_d        = isr_q;
        err_d        = err_q;
        bus.ir_load  = 1'b0;
        bus.src_en   = 1'b0;
        bus.dst_en   = 1'b0;
        bus.imm_en   = 1'b0;
        bus.reg_we   = 1'b0;
        bus.link     = 1'b0;
        bus.wb_sel   = 2'b00;
        bus.b_sel    = 1'b0;
        bus.alu_op   = 4'b0000;
        bus.flags_we = 1'b0;
        bus.mem_req  = 1'b0;
        bus.mem_we   = 1'b0;
        bus.addr_sel = 1'b0;
        bus.pc_op    = 2'b00;
        bus.pc_vec   = 1'b0;
        bus.irq_ack  = 1'b0;
        bus.halted   = 1'b0;
        bus.err_code = 2'b00;

        if (reset) begin
            bus.err_code = err_q;
            case (state_q)
                StFetch: begin
                    // The interrupt is only sampled before a fetch request is issued.
                    if ((cnt_q == '0) && IRQ_EN && bus.irq && !isr_q) begin
                        state_d = StIntr;
                    end else begin
                        bus.mem_req = 1'b1;
                        if (bus.mem_ready) begin
                            bus.ir_load = 1'b1;
                            cnt_d       = '0;
                            state_d     = StDecode;
                        end else if (timeout_hit) begin
                            cnt_d   = '0;
                            err_d   = 2'b01;
                            state_d = StHalt;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end

                StDecode: begin
                    case (cls)
                        CBad: begin
                            err_d   = 2'b10;
                            state_d = StHalt;
                        end
                        CLshi, CBcond, CAndi, COri, CXori, CAddi, CSubi, CCmpi, CMovi, CLui: begin
                            bus.imm_en = 1'b1;
                            bus.dst_en = 1'b1;
                            state_d    = StExec;
                        end
                        default: begin
                            bus.src_en = 1'b1;
                            bus.dst_en = 1'b1;
                            state_d    = ((cls == CLoad) || (cls == CStor)) ? StMem : StExec;
                        end
                    endcase
                end

                StExec: begin
                    state_d   = StFetch;
                    bus.pc_op = 2'b01;
                    case (cls)
                        CAdd, CAddi: begin
                            bus.alu_op   = 4'b1000;
                            bus.reg_we   = 1'b1;
                            bus.flags_we = 1'b1;
                        end
                        CSub, CSubi: begin
                            bus.alu_op   = 4'b0001;
                            bus.reg_we   = 1'b1;
                            bus.flags_we = 1'b1;
                        end
                        CCmp, CCmpi: begin
                            bus.alu_op   = 4'b0010;
                            bus.flags_we = 1'b1;
                        end
                        CAnd, CAndi: begin
                            bus.alu_op = 4'b0011;
                            bus.reg_we = 1'b1;
                        end
                        COr, COri: begin
                            bus.alu_op = 4'b0100;
                            bus.reg_we = 1'b1;
                        end
                        CXor, CXori: begin
                            bus.alu_op = 4'b0101;
                            bus.reg_we = 1'b1;
                        end
                        CLui: begin
                            bus.alu_op = 4'b0110;
                            bus.reg_we = 1'b1;
                        end
                        CLsh, CLshi: begin
                            bus.alu_op = 4'b0111;
                            bus.reg_we = 1'b1;
                        end
                        CMov, CMovi: begin
                            bus.reg_we = 1'b1;
                            bus.wb_sel = 2'b10;
                        end
                        CJal: begin
                            bus.reg_we = 1'b1;
                            bus.wb_sel = 2'b11;
                            bus.pc_op  = 2'b10;
                        end
                        CJcond: begin
                            bus.pc_op = cond_true ? 2'b10 : 2'b01;
                            if (is_return) isr_d = 1'b0;
                        end
                        CBcond: begin
                            bus.pc_op = cond_true ? 2'b11 : 2'b01;
                        end
                        default: ;
                    endcase
                    case (cls)
                        CAndi, COri, CXori, CAddi, CSubi, CCmpi, CMovi, CLui, CLshi:
                            bus.b_sel = 1'b1;
                        default: ;
                    endcase
                end

                StMem: begin
                    bus.mem_req  = 1'b1;
                    bus.addr_sel = 1'b1;
                    bus.mem_we   = (cls == CStor);
                    if (bus.mem_ready) begin
                        if (cls == CLoad) begin
                            bus.reg_we = 1'b1;
                            bus.wb_sel = 2'b01;
                        end
                        bus.pc_op = 2'b01;
                        cnt_d     = '0;
                        state_d   = StFetch;
                    end else if (timeout_hit) begin
                        cnt_d   = '0;
                        err_d   = 2'b01;
                        state_d = StHalt;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end

                StIntr: begin
                    bus.reg_we  = 1'b1;
                    bus.link    = 1'b1;
                    bus.wb_sel  = 2'b11;
                    bus.pc_vec  = 1'b1;
                    bus.irq_ack = 1'b1;
                    isr_d       = 1'b1;
                    state_d     = StFetch;
                end

                StHalt: begin
                    bus.halted = 1'b1;
                end

                default: state_d = StHalt;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: directed steps followed by randomized instructions,
// every cycle's outputs compared against an instruction-level reference model.
module tb_cpu_ctrl_fsm;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cpu_ctrl_fsm_if bus ();

    cpu_ctrl_fsm #(
        .MEM_TIMEOUT(16),
        .TMR_W      (8),
        .LINK_REG   (15),
        .IRQ_EN     (1'b1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic       ir_load;
        logic       src_en;
        logic       dst_en;
        logic       imm_en;
        logic       reg_we;
        logic       link;
        logic [1:0] wb_sel;
        logic       b_sel;
        logic [3:0] alu_op;
        logic       flags_we;
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic [1:0] pc_op;
        logic       pc_vec;
        logic       irq_ack;
        logic       halted;
        logic [1:0] err_code;
    } outs_t;

    typedef enum int {
        MN_BAD, MN_ADD, MN_SUB, MN_CMP, MN_AND, MN_OR, MN_XOR, MN_MOV,
        MN_LOAD, MN_STOR, MN_JAL, MN_JCOND, MN_LSH, MN_LSHI, MN_BCOND,
        MN_ANDI, MN_ORI, MN_XORI, MN_ADDI, MN_SUBI, MN_CMPI, MN_MOVI, MN_LUI
    } mn_t;

    int checks = 0;
    int errors = 0;
    bit m_isr  = 1'b0;

    function automatic outs_t sample();
        outs_t s;
        s.ir_load  = bus.ir_load;   s.src_en   = bus.src_en;   s.dst_en  = bus.dst_en;
        s.imm_en   = bus.imm_en;    s.reg_we   = bus.reg_we;   s.link    = bus.link;
        s.wb_sel   = bus.wb_sel;    s.b_sel    = bus.b_sel;    s.alu_op  = bus.alu_op;
        s.flags_we = bus.flags_we;  s.mem_req  = bus.mem_req;  s.mem_we  = bus.mem_we;
        s.addr_sel = bus.addr_sel;  s.pc_op    = bus.pc_op;    s.pc_vec  = bus.pc_vec;
        s.irq_ack  = bus.irq_ack;   s.halted   = bus.halted;   s.err_code = bus.err_code;
        return s;
    endfunction

    task automatic chk(input string tag, input outs_t got, input outs_t exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s t=%0t instr=%h observed=%h expected=%h", tag, $time, bus.instr,
                   got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic mn_t mnem(input logic [15:0] i);
        logic [3:0] op  = i[15:12];
        logic [3:0] ext = i[7:4];
        case (op)
            4'h0: case (ext)
                      4'h5: return MN_ADD;  4'h9: return MN_SUB;  4'hB: return MN_CMP;
                      4'h1: return MN_AND;  4'h2: return MN_OR;   4'h3: return MN_XOR;
                      4'hD: return MN_MOV;  default: return MN_BAD;
                  endcase
            4'h4: case (ext)
                      4'h0: return MN_LOAD; 4'h4: return MN_STOR;
                      4'h8: return MN_JAL;  4'hC: return MN_JCOND;
                      default: return MN_BAD;
                  endcase
            4'h8: begin
                if (ext == 4'h4) return MN_LSH;
                if (ext == 4'h0 || ext == 4'h1) return MN_LSHI;
                return MN_BAD;
            end
            4'hC: return MN_BCOND;
            4'h1: return MN_ANDI;  4'h2: return MN_ORI;   4'h3: return MN_XORI;
            4'h5: return MN_ADDI;  4'h9: return MN_SUBI;  4'hB: return MN_CMPI;
            4'hD: return MN_MOVI;  4'hF: return MN_LUI;
            default: return MN_BAD;
        endcase
    endfunction

    function automatic bit imm_alu(input mn_t m);
        return m inside {MN_LSHI, MN_ANDI, MN_ORI, MN_XORI, MN_ADDI, MN_SUBI, MN_CMPI,
                         MN_MOVI, MN_LUI};
    endfunction

    // Conditions come in pairs: odd codes are the negation of the even code below them.
    function automatic bit cond_true(input logic [3:0] c, input logic [4:0] fl);
        bit cf = fl[4], lf = fl[3], ff = fl[2], zf = fl[1], nf = fl[0];
        bit base;
        case (c[3:1])
            3'd0: base = zf;
            3'd1: base = cf;
            3'd2: base = lf;
            3'd3: base = nf;
            3'd4: base = ff;
            3'd5: base = !lf && !zf;
            3'd6: base = !nf && !zf;
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    function automatic outs_t exp_decode(input logic [15:0] i);
        outs_t o = '0;
        mn_t   m = mnem(i);
        if (m == MN_BAD) return o;
        o.dst_en = 1'b1;
        if (imm_alu(m) || m == MN_BCOND) o.imm_en = 1'b1;
        else                             o.src_en = 1'b1;
        return o;
    endfunction

    function automatic outs_t exp_exec(input logic [15:0] i, input logic [4:0] fl);
        outs_t o = '0;
        mn_t   m = mnem(i);
        bit    t = cond_true(i[11:8], fl);
        o.pc_op = 2'b01;
        case (m)
            MN_ADD, MN_ADDI: begin o.alu_op = 4'b1000; o.reg_we = 1; o.flags_we = 1; end
            MN_SUB, MN_SUBI: begin o.alu_op = 4'b0001; o.reg_we = 1; o.flags_we = 1; end
            MN_CMP, MN_CMPI: begin o.alu_op = 4'b0010; o.flags_we = 1; end
            MN_AND, MN_ANDI: begin o.alu_op = 4'b0011; o.reg_we = 1; end
            MN_OR,  MN_ORI:  begin o.alu_op = 4'b0100; o.reg_we = 1; end
            MN_XOR, MN_XORI: begin o.alu_op = 4'b0101; o.reg_we = 1; end
            MN_LUI:          begin o.alu_op = 4'b0110; o.reg_we = 1; end
            MN_LSH, MN_LSHI: begin o.alu_op = 4'b0111; o.reg_we = 1; end
            MN_MOV, MN_MOVI: begin o.reg_we = 1; o.wb_sel = 2'b10; end
            MN_JAL:          begin o.reg_we = 1; o.wb_sel = 2'b11; o.pc_op = 2'b10; end
            MN_JCOND:        o.pc_op = t ? 2'b10 : 2'b01;
            MN_BCOND:        o.pc_op = t ? 2'b11 : 2'b01;
            default: ;
        endcase
        o.b_sel = imm_alu(m);
        return o;
    endfunction

    function automatic outs_t exp_halt(input logic [1:0] err);
        outs_t o = '0;
        o.halted   = 1'b1;
        o.err_code = err;
        return o;
    endfunction

    function automatic outs_t exp_intr();
        outs_t o = '0;
        o.reg_we = 1; o.link = 1; o.wb_sel = 2'b11; o.pc_vec = 1; o.irq_ack = 1;
        return o;
    endfunction

    function automatic outs_t exp_mem(input bit store, input bit rdy);
        outs_t o = '0;
        o.mem_req = 1; o.addr_sel = 1; o.mem_we = store;
        if (rdy) begin
            o.pc_op = 2'b01;
            if (!store) begin o.reg_we = 1; o.wb_sel = 2'b01; end
        end
        return o;
    endfunction

    // Drive one instruction from its FETCH first cycle to its last cycle, checking each
    // cycle. mdly < 0 means memory never answers in MEM.
    task automatic run_instr(input logic [15:0] i, input logic [4:0] fl, input int fdly,
                             input int mdly, output bit halted_out);
        mn_t   m = mnem(i);
        outs_t e;
        halted_out = 1'b0;
        bus.instr = i;
        bus.flags = fl;
        bus.mem_ready = 1'b0;
        if (bus.irq && !m_isr) begin
            settle(); chk("irq_fetch", sample(), '0); tick();
            settle(); chk("intr", sample(), exp_intr()); tick();
            m_isr = 1'b1;
        end
        for (int k = 0; k <= fdly; k++) begin
            bus.mem_ready = (k == fdly);
            settle();
            e = '0; e.mem_req = 1'b1; e.ir_load = (k == fdly);
            chk("fetch", sample(), e);
            tick();
        end
        bus.mem_ready = 1'b0;
        settle(); chk("decode", sample(), exp_decode(i)); tick();
        if (m == MN_BAD) begin
            settle(); chk("halt_illegal", sample(), exp_halt(2'b10));
            halted_out = 1'b1;
            return;
        end
        if (m == MN_LOAD || m == MN_STOR) begin
            if (mdly < 0) begin
                for (int k = 0; k < 16; k++) begin
                    settle(); chk("mem_wait", sample(), exp_mem(m == MN_STOR, 1'b0)); tick();
                end
                settle(); chk("halt_mem_timeout", sample(), exp_halt(2'b01));
                halted_out = 1'b1;
                return;
            end
            for (int k = 0; k <= mdly; k++) begin
                bus.mem_ready = (k == mdly);
                settle(); chk("mem", sample(), exp_mem(m == MN_STOR, k == mdly)); tick();
            end
            bus.mem_ready = 1'b0;
        end else begin
            settle(); chk("exec", sample(), exp_exec(i, fl));
            if (m == MN_JCOND && i[11:8] == 4'hE && i[3:0] == 4'd15) m_isr = 1'b0;
            tick();
        end
    endtask

    task automatic do_reset();
        bus.irq = 1'b0;
        bus.mem_ready = 1'b0;
        reset = 1'b0;
        settle(); chk("in_reset", sample(), '0);
        tick();
        reset = 1'b1;
        m_isr = 1'b0;
    endtask

    function automatic logic [15:0] rand_legal();
        logic [15:0] r = 16'h0152;
        for (int n = 0; n < 64; n++) begin
            r = 16'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 2))
                    0: r[15:12] = 4'h0;
                    1: r[15:12] = 4'h4;
                    default: r[15:12] = 4'h8;
                endcase
            end
            if (mnem(r) != MN_BAD) return r;
        end
        return 16'h0152;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          h;
        logic [4:0]  fsets [6];
        logic [15:0] r;
        outs_t       e;

        fsets[0] = 5'b00010; fsets[1] = 5'b01000; fsets[2] = 5'b00001;
        fsets[3] = 5'b10000; fsets[4] = 5'b00100; fsets[5] = 5'b00000;

        bus.instr = 16'h0000; bus.flags = 5'b0; bus.irq = 1'b0; bus.mem_ready = 1'b0;
        #2;
        chk("reset_state", sample(), '0);
        tick();
        reset = 1'b1;

        // ADDI, memory ready at once: FETCH, DECODE, EXEC
        run_instr(16'h5105, 5'b0, 0, 0, h);
        // LOAD with four wait cycles in MEM; STOR with one
        run_instr(16'h4301, 5'b0, 0, 4, h);
        run_instr(16'h4341, 5'b0, 1, 1, h);
        // Ready on the very cycle the counter reaches the timeout wins
        run_instr(16'h0152, 5'b0, 15, 0, h);
        run_instr(16'h4301, 5'b0, 0, 15, h);

        // Condition sweep
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 6; f++) begin
                r = 16'hC000 | 16'(c << 8) | 16'($urandom_range(0, 255));
                run_instr(r, fsets[f], 0, 0, h);
            end
        end

        // Interrupt, blocked nesting, non-return jumps, return, second interrupt
        bus.irq = 1'b1;
        run_instr(16'h0152, 5'b0, 0, 0, h);
        run_instr(16'h0152, 5'b0, 0, 0, h);
        run_instr(16'h4ECE, 5'b0, 0, 0, h);
        run_instr(16'h40CF, 5'b0, 0, 0, h);
        run_instr(16'h4ECF, 5'b0, 0, 0, h);
        run_instr(16'h5105, 5'b0, 0, 0, h);
        bus.irq = 1'b0;
        run_instr(16'h4ECF, 5'b0, 0, 0, h);
        run_instr(16'h0152, 5'b0, 0, 0, h);

        // Fetch timeout, HALT ignores irq, reset recovers
        bus.instr = 16'h0152;
        bus.mem_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            settle(); e = '0; e.mem_req = 1'b1; chk("fetch_wait", sample(), e); tick();
        end
        settle(); chk("halt_timeout", sample(), exp_halt(2'b01));
        bus.irq = 1'b1;
        tick(); settle(); chk("halt_irq", sample(), exp_halt(2'b01));
        tick(); settle(); chk("halt_sticky", sample(), exp_halt(2'b01));
        do_reset();
        settle(); e = '0; e.mem_req = 1'b1; chk("fetch_after_reset", sample(), e);
        run_instr(16'h0152, 5'b0, 0, 0, h);

        // MEM timeout
        run_instr(16'h4301, 5'b0, 0, -1, h);
        do_reset();

        // Illegal opcode
        run_instr(16'h7000, 5'b0, 0, 0, h);
        tick(); settle(); chk("halt_illegal_sticky", sample(), exp_halt(2'b10));
        do_reset();

        // Reset asserted mid-MEM
        bus.instr = 16'h4301;
        bus.mem_ready = 1'b1; settle(); tick();
        bus.mem_ready = 1'b0; settle(); tick();
        settle(); chk("mem_before_reset", sample(), exp_mem(1'b0, 1'b0));
        #2;
        reset = 1'b0;
        #1;
        chk("reset_mid_mem", sample(), '0);
        tick();
        reset = 1'b1;
        m_isr = 1'b0;
        settle(); e = '0; e.mem_req = 1'b1; chk("fetch_after_mid_reset", sample(), e);
        run_instr(16'h0152, 5'b0, 0, 0, h);

        // Randomized instruction stream
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0)      r = 16'($urandom);
            else if ($urandom_range(0, 7) == 0) r = 16'h4ECF;
            else                                r = rand_legal();
            bus.irq = ($urandom_range(0, 5) == 0);
            run_instr(r, 5'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), h);
            if (h) begin
                tick();
                do_reset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
